// File: rtl/camera_follower.sv
// Per-frame camera smoother/clamp; optional deadzone under CAMERA_DEADZONE_EN.
// frame_start at edge E -> new camera and one-cycle valid after E+4; target ready only in IDLE.
module camera_follower #(
  parameter int SMOOTH_SHIFT = 3,
  parameter int DEADZONE     = 16,
  parameter int CAM_MIN_X    = -100000,
  parameter int CAM_MAX_X    = 100000,
  parameter int CAM_MIN_Y    = -100000,
  parameter int CAM_MAX_Y    = 100000,
  parameter int RESET_X      = 0,
  parameter int RESET_Y      = 0
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               target_valid_in,
  output logic               target_ready_out,
  input  logic signed [31:0] target_x_in,
  input  logic signed [31:0] target_y_in,
  input  logic               frame_start_in,
  input  logic               snap_in,
  output logic signed [31:0] camera_x_out,
  output logic signed [31:0] camera_y_out,
  output logic               camera_valid_out
);

`ifdef CAMERA_DEADZONE_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_DIFF, S_STEP, S_CLAMP, S_COMMIT} state_t;

  state_t             r_state, w_next;
  logic signed [31:0] r_tx, r_ty, r_cam_x, r_cam_y, r_nx, r_ny;
  logic signed [32:0] r_dx, r_dy, r_sx, r_sy;
  logic               r_have, r_snap, r_cam_vld;
  logic               w_xfer;

  // Floor shift, but never a zero step for a nonzero distance unless the deadzone holds it.
  function automatic logic signed [32:0] f_step(input logic signed [32:0] d, input logic snap);
    logic signed [32:0] s;
    logic        [32:0] mag;
    s   = d >>> SMOOTH_SHIFT;
    mag = d[32] ? 33'(-d) : 33'(d);
    if (d != '0 && s == '0) s = d[32] ? -33'sd1 : 33'sd1;
    if (DZ_EN && mag <= 33'(DEADZONE)) s = '0;
    if (snap) s = d;
    return s;
  endfunction

  function automatic logic signed [31:0] f_clamp(input logic signed [31:0] c,
                                                 input logic signed [32:0] s,
                                                 input int mn, input int mx);
    logic signed [33:0] n;
    n = 34'(c) + 34'(s);
    if (n < 34'(mn)) return 32'(mn);
    if (n > 34'(mx)) return 32'(mx);
    return n[31:0];
  endfunction

  assign target_ready_out = (r_state == S_IDLE);
  assign w_xfer           = target_valid_in && target_ready_out;
  assign camera_x_out     = r_cam_x;
  assign camera_y_out     = r_cam_y;
  assign camera_valid_out = r_cam_vld;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (frame_start_in && (r_have || w_xfer)) w_next = S_DIFF;
      S_DIFF:   w_next = S_STEP;
      S_STEP:   w_next = S_CLAMP;
      S_CLAMP:  w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= S_IDLE;
      r_tx      <= '0;
      r_ty      <= '0;
      r_have    <= 1'b0;
      r_snap    <= 1'b0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_sx      <= '0;
      r_sy      <= '0;
      r_nx      <= '0;
      r_ny      <= '0;
      r_cam_x   <= 32'(RESET_X);
      r_cam_y   <= 32'(RESET_Y);
      r_cam_vld <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cam_vld <= 1'b0;
      if (w_xfer) begin
        r_tx   <= target_x_in;
        r_ty   <= target_y_in;
        r_have <= 1'b1;
      end
      case (r_state)
        S_IDLE:   if (w_next == S_DIFF) r_snap <= snap_in;
        S_DIFF: begin
          r_dx <= 33'(r_tx) - 33'(r_cam_x);
          r_dy <= 33'(r_ty) - 33'(r_cam_y);
        end
        S_STEP: begin
          r_sx <= f_step(r_dx, r_snap);
          r_sy <= f_step(r_dy, r_snap);
        end
        S_CLAMP: begin
          r_nx <= f_clamp(r_cam_x, r_sx, CAM_MIN_X, CAM_MAX_X);
          r_ny <= f_clamp(r_cam_y, r_sy, CAM_MIN_Y, CAM_MAX_Y);
        end
        S_COMMIT: begin
          r_cam_x   <= r_nx;
          r_cam_y   <= r_ny;
          r_cam_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_follower.sv
// Randomized self-checking bench for camera_follower against an arithmetic reference model.
module tb_camera_follower;
  localparam int  SHIFT = 3;
  localparam int  DZ    = 16;
  localparam int  MINX  = -10000;
  localparam int  MAXX  = 10000;
  localparam int  MINY  = -100000;
  localparam int  MAXY  = 100000;
  localparam int  RX    = 5;
  localparam int  RY    = -7;
  localparam longint TMIN = -64'sd2147483648;
  localparam longint TMAX = 64'sd2147483647;

  logic clk = 1'b0, rst_n = 1'b0, tvld = 1'b0, frame = 1'b0, snap = 1'b0;
  logic signed [31:0] tx = '0, ty = '0;
  logic tready, cvld;
  logic signed [31:0] cx, cy;

  int n_checks = 0, n_fail = 0;
  longint m_cx, m_cy, m_tx, m_ty;
  bit m_have;

  camera_follower #(
    .SMOOTH_SHIFT(SHIFT), .DEADZONE(DZ), .CAM_MIN_X(MINX), .CAM_MAX_X(MAXX),
    .CAM_MIN_Y(MINY), .CAM_MAX_Y(MAXY), .RESET_X(RX), .RESET_Y(RY)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .target_valid_in(tvld), .target_ready_out(tready),
    .target_x_in(tx), .target_y_in(ty), .frame_start_in(frame), .snap_in(snap),
    .camera_x_out(cx), .camera_y_out(cy), .camera_valid_out(cvld)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: move a fraction of the distance, at least one unit, then saturate.
  function automatic longint step_axis(longint c, longint t, bit s, longint mn, longint mx);
    longint d, q, n, div;
    div = longint'(1) << SHIFT;
    d = t - c;
    if (s) q = d;
    else if (d >= 0) q = d / div;
    else q = -((-d + div - 1) / div);
    if (!s && q == 0 && d != 0) q = (d > 0) ? 1 : -1;
`ifdef CAMERA_DEADZONE_EN
    if (!s && ((d < 0) ? -d : d) <= DZ) q = 0;
`endif
    n = c + q;
    if (n < mn) n = mn;
    if (n > mx) n = mx;
    return n;
  endfunction

  task automatic model_frame(input bit s);
    if (m_have) begin
      m_cx = step_axis(m_cx, m_tx, s, MINX, MAXX);
      m_cy = step_axis(m_cy, m_ty, s, MINY, MAXY);
    end
  endtask

  task automatic model_reset();
    m_cx = RX; m_cy = RY; m_have = 0;
  endtask

  task automatic send_target(input longint x, input longint y);
    int w;
    @(negedge clk);
    tvld = 1'b1; tx = 32'(x); ty = 32'(y); w = 0;
    while (!tready && w < 50) begin @(negedge clk); w++; end
    n_checks++;
    if (w >= 50) begin
      n_fail++;
      $display("FAIL send_target: ready never seen, waited %0d cycles, required < 50", w);
    end
    @(posedge clk);
    m_tx = x; m_ty = y; m_have = 1;
    #1 tvld = 1'b0;
  endtask

  task automatic run_frame(input bit s, output int pulses, output int lat,
                           output logic signed [31:0] ox, output logic signed [31:0] oy);
    @(negedge clk);
    frame = 1'b1; snap = s;
    @(posedge clk);
    #1 frame = 1'b0; snap = 1'b0;
    pulses = 0; lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (cvld) begin pulses++; lat = k; end
    end
    ox = cx; oy = cy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (cx !== RX) begin n_fail++; $display("FAIL reset_x: got %0d want %0d", cx, RX); end
    n_checks++; if (cy !== RY) begin n_fail++; $display("FAIL reset_y: got %0d want %0d", cy, RY); end
    n_checks++; if (cvld !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cvld); end
    n_checks++; if (tready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tready); end
    @(negedge clk) rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_no_target();
    int p, l; logic signed [31:0] ox, oy;
    run_frame(0, p, l, ox, oy);
    n_checks++; if (p !== 0) begin n_fail++; $display("FAIL no_target_pulse: got %0d pulses want 0", p); end
    n_checks++; if (ox !== RX || oy !== RY) begin n_fail++; $display("FAIL no_target_pos: got (%0d,%0d) want (%0d,%0d)", ox, oy, RX, RY); end
  endtask

  task automatic test_smoothing();
    int p, l; logic signed [31:0] ox, oy;
    send_target(0, 0);
    run_frame(1, p, l, ox, oy); model_frame(1);
    n_checks++; if (ox !== 0 || oy !== 0) begin n_fail++; $display("FAIL smooth_home: got (%0d,%0d) want (0,0)", ox, oy); end
    send_target(800, -40);
    run_frame(0, p, l, ox, oy); model_frame(0);
    n_checks++; if (p !== 1 || l !== 4) begin n_fail++; $display("FAIL smooth_pulse: got %0d pulses at %0d want 1 at 4", p, l); end
    n_checks++; if (ox !== 100 || oy !== -5 || ox !== m_cx) begin n_fail++; $display("FAIL smooth_f1: got (%0d,%0d) want (100,-5)", ox, oy); end
    run_frame(0, p, l, ox, oy); model_frame(0);
    n_checks++; if (ox !== 187 || oy !== -10 || oy !== m_cy) begin n_fail++; $display("FAIL smooth_f2: got (%0d,%0d) want (187,-10)", ox, oy); end
  endtask

`ifndef CAMERA_DEADZONE_EN
  task automatic test_convergence();
    int p, l, e; logic signed [31:0] ox, oy;
    send_target(0, 0);
    run_frame(1, p, l, ox, oy); model_frame(1);
    send_target(3, -3);
    for (int i = 0; i < 5; i++) begin
      run_frame(0, p, l, ox, oy); model_frame(0);
      e = (i < 3) ? i + 1 : 3;
      n_checks++;
      if (p !== 1 || ox !== e || oy !== -e || ox !== m_cx) begin
        n_fail++; $display("FAIL converge_%0d: got (%0d,%0d) pulses %0d want (%0d,%0d) pulses 1", i, ox, oy, p, e, -e);
      end
    end
  endtask
`else
  task automatic test_deadzone();
    int p, l; logic signed [31:0] ox, oy;
    send_target(0, 0);
    run_frame(1, p, l, ox, oy); model_frame(1);
    send_target(10, 0);
    for (int i = 0; i < 5; i++) begin
      run_frame(0, p, l, ox, oy); model_frame(0);
      n_checks++;
      if (p !== 1 || ox !== 0 || oy !== 0) begin
        n_fail++; $display("FAIL deadzone_hold_%0d: got (%0d,%0d) pulses %0d want (0,0) pulses 1", i, ox, oy, p);
      end
    end
    send_target(17, 0);
    run_frame(0, p, l, ox, oy); model_frame(0);
    n_checks++; if (ox !== 2 || ox !== m_cx) begin n_fail++; $display("FAIL deadzone_move: got %0d want 2", ox); end
  endtask
`endif

  task automatic test_snap_clamp();
    int p, l; logic signed [31:0] ox, oy;
    send_target(9990, 0);
    run_frame(1, p, l, ox, oy); model_frame(1);
    n_checks++; if (ox !== 9990) begin n_fail++; $display("FAIL snap_9990: got %0d want 9990", ox); end
    send_target(20000, 0);
    run_frame(1, p, l, ox, oy); model_frame(1);
    n_checks++; if (ox !== MAXX) begin n_fail++; $display("FAIL snap_clamp_max: got %0d want %0d", ox, MAXX); end
    send_target(TMIN, TMAX);
    run_frame(1, p, l, ox, oy); model_frame(1);
    n_checks++; if (ox !== MINX || oy !== MAXY) begin n_fail++; $display("FAIL snap_extreme: got (%0d,%0d) want (%0d,%0d)", ox, oy, MINX, MAXY); end
    send_target(TMAX, TMIN);
    run_frame(0, p, l, ox, oy); model_frame(0);
    n_checks++; if (ox !== m_cx || oy !== m_cy) begin n_fail++; $display("FAIL smooth_extreme: got (%0d,%0d) want (%0d,%0d)", ox, oy, m_cx, m_cy); end
  endtask

  task automatic test_handshake();
    int p, l, extra; logic signed [31:0] ox, oy;
    send_target(500, 500);
    @(negedge clk); frame = 1'b1; snap = 1'b0;
    @(posedge clk); #1 frame = 1'b0;
    model_frame(0);
    @(posedge clk); #1;
    tvld = 1'b1; tx = -700; ty = 300;
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_step: got %b want 0", tready); end
    @(posedge clk); #1 frame = 1'b1;
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_clamp: got %b want 0", tready); end
    @(posedge clk); #1 frame = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (cvld !== 1'b1 || tready !== 1'b1 || cx !== m_cx || cy !== m_cy) begin
      n_fail++; $display("FAIL hs_commit: got vld %b rdy %b (%0d,%0d) want 1 1 (%0d,%0d)", cvld, tready, cx, cy, m_cx, m_cy);
    end
    @(posedge clk);
    m_tx = -700; m_ty = 300;
    #1 tvld = 1'b0;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (cvld) extra++;
      @(posedge clk); #1;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL hs_single_pulse: got %0d extra pulses want 0", extra); end
    run_frame(0, p, l, ox, oy); model_frame(0);
    n_checks++; if (p !== 1 || ox !== m_cx || oy !== m_cy) begin n_fail++; $display("FAIL hs_new_target: got (%0d,%0d) want (%0d,%0d)", ox, oy, m_cx, m_cy); end
  endtask

  task automatic test_back_to_back();
    int p; longint x, y;
    for (int i = 0; i < 3; i++) begin
      x = longint'($urandom_range(0, 20000)) - 10000;
      y = longint'($urandom_range(0, 20000)) - 10000;
      @(negedge clk);
      tvld = 1'b1; tx = 32'(x); ty = 32'(y); frame = 1'b1; snap = 1'b0;
      @(posedge clk);
      m_tx = x; m_ty = y; m_have = 1;
      #1 tvld = 1'b0; frame = 1'b0;
      model_frame(0);
      p = 0;
      for (int k = 0; k < 4; k++) begin @(posedge clk); #1; if (cvld) p++; end
      n_checks++;
      if (p !== 1 || cx !== m_cx || cy !== m_cy) begin
        n_fail++; $display("FAIL b2b_%0d: got (%0d,%0d) pulses %0d want (%0d,%0d) pulses 1", i, cx, cy, p, m_cx, m_cy);
      end
    end
  endtask

  task automatic test_random();
    int p, l; logic signed [31:0] ox, oy; longint x, y; bit s;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        x = longint'($signed($urandom)); y = longint'($signed($urandom));
      end else begin
        x = longint'($urandom_range(0, 30000)) - 15000;
        y = longint'($urandom_range(0, 300000)) - 150000;
      end
      s = ($urandom_range(0, 4) == 0);
      send_target(x, y);
      run_frame(s, p, l, ox, oy); model_frame(s);
      n_checks++;
      if (p !== 1 || l !== 4 || ox !== m_cx || oy !== m_cy) begin
        n_fail++; $display("FAIL random_%0d: got (%0d,%0d) pulses %0d lat %0d want (%0d,%0d) pulses 1 lat 4", i, ox, oy, p, l, m_cx, m_cy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int p, l; logic signed [31:0] ox, oy;
    send_target(4000, -4000);
    @(negedge clk); frame = 1'b1;
    @(posedge clk); #1 frame = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (cx !== RX || cy !== RY || cvld !== 1'b0 || tready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid: got (%0d,%0d) vld %b rdy %b want (%0d,%0d) 0 1", cx, cy, cvld, tready, RX, RY);
    end
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    run_frame(0, p, l, ox, oy);
    n_checks++; if (p !== 0 || ox !== RX || oy !== RY) begin n_fail++; $display("FAIL rst_mid_no_update: got (%0d,%0d) pulses %0d want (%0d,%0d) pulses 0", ox, oy, p, RX, RY); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_no_target();
    test_smoothing();
`ifndef CAMERA_DEADZONE_EN
    test_convergence();
`else
    test_deadzone();
`endif
    test_snap_clamp();
    test_handshake();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/camera_follower.md
# camera_follower

Per-frame camera controller directly upstream of the pixel-to-world stage. It accepts car target positions over a valid/ready handshake. Once per video frame it moves the camera a smoothed step toward the latest target and clamps the result to world bounds. It then presents a stable `camera_x_out`/`camera_y_out` pair for the coordinate-conversion stage. The camera never changes during active video; it updates only after a frame-start pulse.

## Interface
- `SMOOTH_SHIFT`, 3: step = distance >>> SMOOTH_SHIFT; legal range 0–8.
- `DEADZONE`, 16: a non-negative distance in world units; no motion occurs on an axis while |distance| ≤ DEADZONE. Used only when `CAMERA_DEADZONE_EN` is defined.
- `CAM_MIN_X`, -100000; `CAM_MAX_X`, 100000: inclusive camera X bounds.
- `CAM_MIN_Y`, -100000; `CAM_MAX_Y`, 100000: inclusive camera Y bounds.
- `RESET_X`, 0; `RESET_Y`, 0: camera position after reset; must lie within bounds.

Ports:
- `clk_in` input 1: single clock.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `target_valid_in` input 1: target offer.
- `target_ready_out` output 1: high exactly while FSM is in IDLE.
- `target_x_in`, `target_y_in` input 32 signed: target world position.
- `frame_start_in` input 1: one-cycle pulse at start of vertical blanking.
- `snap_in` input 1: sampled with `frame_start_in`; when high, camera jumps straight to target (still clamped).
- `camera_x_out`, `camera_y_out` output 32 signed: registered camera position.
- `camera_valid_out` output 1: one-cycle pulse when a new camera position commits.

## Operation
- Target capture:
  - A transfer occurs on a rising edge with `target_valid_in && target_ready_out`. It overwrites the target registers (latest wins) and sets `have_target`.
- FSM states: IDLE → DIFF → STEP → CLAMP → COMMIT → IDLE.
- IDLE:
  - `frame_start_in` with `have_target` set goes to DIFF and latches `snap_in`.
  - `frame_start_in` without `have_target` is ignored.
- DIFF: d = target − camera per axis, computed 33-bit signed.
- STEP, per axis:
  - If snap is latched, s = d.
  - Otherwise, s = d >>> SMOOTH_SHIFT (arithmetic, floor).
  - If d ≠ 0 and the shift gives s = 0, s = sign(d), i.e. ±1, so the camera always converges.
  - With deadzone enabled, s = 0 when |d| ≤ DEADZONE; this overrides the ±1 rule but not snap.
- CLAMP: n = camera + s in 34 bits, saturated to [CAM_MIN, CAM_MAX] per axis.
- COMMIT: writes n to the camera outputs, pulses `camera_valid_out`, returns to IDLE.
- `frame_start_in` outside IDLE is ignored; no queueing.
- Target offers outside IDLE stall because ready is low; the offering side holds `valid` and data.

## Timing
- Reset values (asynchronous, immediate on `rst_n_in` low):
  - `camera_x_out` = RESET_X, `camera_y_out` = RESET_Y.
  - `camera_valid_out` = 0.
  - `target_ready_out` = 1 (FSM in IDLE).
  - `have_target` = 0; snap latch = 0.
- Latency: `frame_start_in` sampled at edge E → FSM enters DIFF at E. The new camera value and `camera_valid_out` = 1 are visible after edge E+4, for exactly one cycle.
- Camera outputs are constant in all other cycles.
- Transfer and frame start on the same edge: the newly transferred target is used for that frame.
- Reset mid-operation (any non-IDLE state): FSM aborts to IDLE and outputs take reset values. The pending target is discarded, so no update occurs until a new transfer.
- Arithmetic boundaries:
  - 32-bit extremes must not wrap, because of the 33/34-bit intermediates and saturation.
  - The deadzone compare uses |d| in 33 bits, which handles d = −2^32.

## Configuration
- `CAMERA_DEADZONE_EN` defined: the deadzone rule in STEP is active.
- `CAMERA_DEADZONE_EN` undefined: `DEADZONE` is ignored and any nonzero d moves the camera by at least 1 unit.

## Test plan
- Smoothing (SHIFT=3, camera 0, target (800, −40), frame pulse):
  - After 4 edges, outputs are (100, −5) with a one-cycle valid pulse.
  - Next frame gives (187, −10).
- Convergence floor (deadzone off, camera 0, target (3, −3)): each frame moves ±1 until outputs reach (3, −3), then stay.
- Deadzone (`CAMERA_DEADZONE_EN`, DEADZONE=16):
  - Target (10, 0): no motion over 5 frames, but valid still pulses.
  - Target (17, 0): camera moves by 2.
- Snap and clamp (CAM_MAX_X = 10000, camera 9990, target 20000, `snap_in` = 1): `camera_x_out` = 10000.
  - Target −2^31 with snap: X = CAM_MIN_X.
- Handshake:
  - Valid offered during STEP: ready is low and the target is accepted on the first IDLE edge.
  - Frame pulse during CLAMP: ignored, so only one valid pulse occurs.
  - Frame pulse before any target: no valid pulse.
- Reset in STEP: outputs go immediately to (RESET_X, RESET_Y) and valid = 0. A following frame pulse with no new target produces no update.
